// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame sequencer: CSR map, register bit
// positions, FSM states and counter width helper.
package sobel_pkg;

    localparam logic [1:0] CSR_CTRL   = 2'd0;
    localparam logic [1:0] CSR_STATUS = 2'd1;
    localparam logic [1:0] CSR_FCOUNT = 2'd2;
    localparam logic [1:0] CSR_POS    = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_ABORT = 2;
    localparam int CTRL_IE    = 3;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ABORTED = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Counter width for a dimension of n positions, never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sobel_xy_counter.sv
// Raster x/y position counter: advances on each accepted pixel, wraps at the
// frame edges and flags the last pixel of the frame.
module sobel_xy_counter
    import sobel_pkg::*;
#(
    parameter  int IMG_X_SIZE = 100,
    parameter  int IMG_Y_SIZE = 100,
    localparam int XW         = cnt_w(IMG_X_SIZE),
    localparam int YW         = cnt_w(IMG_Y_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_MAX = XW'(IMG_X_SIZE - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_Y_SIZE - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (inc) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frames a raw pixel stream into IMG_X_SIZE x IMG_Y_SIZE packets with SOP/EOP
// under CSR control. Define SOBEL_FRAME_CTRL_IRQ_EN to add the IE bit and irq.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_X_SIZE = 100,
    parameter int IMG_Y_SIZE = 100
) (
    input  logic        csi_clkrst_clk,
    input  logic        csi_clkrst_reset,
    input  logic [1:0]  avs_csr_address,
    input  logic        avs_csr_write,
    input  logic [31:0] avs_csr_writedata,
    input  logic        avs_csr_read,
    output logic [31:0] avs_csr_readdata,
    input  logic [7:0]  asi_sink1_data,
    input  logic        asi_sink1_valid,
    output logic        asi_sink1_ready,
    output logic [7:0]  aso_source1_data,
    output logic        aso_source1_valid,
    input  logic        aso_source1_ready,
    output logic        aso_source1_startofpacket,
`ifdef SOBEL_FRAME_CTRL_IRQ_EN
    output logic        ins_irq0_irq,
`endif
    output logic        aso_source1_endofpacket
);

    localparam int XW = cnt_w(IMG_X_SIZE);
    localparam int YW = cnt_w(IMG_Y_SIZE);

    state_e        state_q, state_d;
    logic          cont_q, cont_d;
    logic          done_q, done_d;
    logic          aborted_q, aborted_d;
    logic [31:0]   fcount_q, fcount_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ie_q, ie_d;

    logic          run, beat, last, clr, frame_done, abort_run;
    logic          wr_ctrl, wr_status, wr_fcount, start_req, abort_req;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          unused_wdata;

    assign unused_wdata = ^avs_csr_writedata[31:3];

    assign wr_ctrl   = avs_csr_write && (avs_csr_address == CSR_CTRL);
    assign wr_status = avs_csr_write && (avs_csr_address == CSR_STATUS);
    assign wr_fcount = avs_csr_write && (avs_csr_address == CSR_FCOUNT);
    assign start_req = wr_ctrl && avs_csr_writedata[CTRL_START];
    assign abort_req = wr_ctrl && avs_csr_writedata[CTRL_ABORT];

    assign run  = (state_q == RUN);
    assign beat = aso_source1_valid && aso_source1_ready;

    sobel_xy_counter #(
        .IMG_X_SIZE(IMG_X_SIZE),
        .IMG_Y_SIZE(IMG_Y_SIZE)
    ) u_xy (
        .clk (csi_clkrst_clk),
        .rst (csi_clkrst_reset),
        .clr (clr),
        .inc (beat),
        .x   (x),
        .y   (y),
        .last(last)
    );

    // Abort outranks both START and a coincident final beat.
    always_comb begin
        state_d    = state_q;
        clr        = 1'b0;
        frame_done = 1'b0;
        abort_run  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_req && !abort_req) begin
                    state_d = RUN;
                    clr     = 1'b1;
                end
            end
            RUN: begin
                if (abort_req) begin
                    state_d   = IDLE;
                    clr       = 1'b1;
                    abort_run = 1'b1;
                end else if (beat && last) begin
                    frame_done = 1'b1;
                    if (!cont_q) state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        cont_d    = wr_ctrl ? avs_csr_writedata[CTRL_CONT] : cont_q;
`ifdef SOBEL_FRAME_CTRL_IRQ_EN
        ie_d      = wr_ctrl ? avs_csr_writedata[CTRL_IE] : ie_q;
`else
        ie_d      = 1'b0;
`endif
        done_d    = done_q;
        aborted_d = aborted_q;
        fcount_d  = fcount_q;
        // Hardware set is applied after the W1C so it wins on collision.
        if (wr_status && avs_csr_writedata[ST_DONE])    done_d    = 1'b0;
        if (wr_status && avs_csr_writedata[ST_ABORTED]) aborted_d = 1'b0;
        if (frame_done) done_d    = 1'b1;
        if (abort_run)  aborted_d = 1'b1;
        if (wr_fcount)       fcount_d = '0;
        else if (frame_done) fcount_d = fcount_q + 32'd1;
    end

    always_comb begin
        rdata_d = '0;
        if (avs_csr_read) begin
            case (avs_csr_address)
                CSR_CTRL: begin
                    rdata_d[CTRL_CONT] = cont_q;
                    rdata_d[CTRL_IE]   = ie_q;
                end
                CSR_STATUS: begin
                    rdata_d[ST_BUSY]    = run;
                    rdata_d[ST_DONE]    = done_q;
                    rdata_d[ST_ABORTED] = aborted_q;
                end
                CSR_FCOUNT: rdata_d = fcount_q;
                default:    rdata_d = {16'(y), 16'(x)};
            endcase
        end
    end

    always_ff @(posedge csi_clkrst_clk) begin
        if (csi_clkrst_reset) begin
            state_q   <= IDLE;
            cont_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            fcount_q  <= '0;
            rdata_q   <= '0;
            ie_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cont_q    <= cont_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            fcount_q  <= fcount_d;
            rdata_q   <= rdata_d;
            ie_q      <= ie_d;
        end
    end

    assign avs_csr_readdata          = rdata_q;
    assign aso_source1_data          = asi_sink1_data;
    assign aso_source1_valid         = asi_sink1_valid && run;
    assign asi_sink1_ready           = aso_source1_ready && run;
    assign aso_source1_startofpacket = run && (x == '0) && (y == '0);
    assign aso_source1_endofpacket   = run && last;

`ifdef SOBEL_FRAME_CTRL_IRQ_EN
    assign ins_irq0_irq = (done_q || aborted_q) && ie_q;
`endif

endmodule
